// File: rtl/mem_access_stage_if.sv
// Data-bus port bundle for the memory access stage.
// The stage is the master; the memory system is the slave.
interface mem_access_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// Execute-to-writeback memory stage: one instruction in flight,
// one bus transaction per load/store, alignment and timeout faults.
module mem_access_stage #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [73:0]               in_pkt,
    input  logic [2:0]                in_funct3,
    input  logic [1:0]                in_memaccess,
    input  logic [31:0]               in_store_data,
    mem_access_stage_if.master        bus,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [31:0]               wb_result,
    output logic [5:0]                wb_cause,
    output logic                      wb_trap,
    output logic                      wb_redirect,
    output logic [1:0]                wb_cmtype
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIM = CW'(RESP_TIMEOUT - 1);

    state_t      state;
    logic [CW-1:0] cnt;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic        st_q;

    logic [5:0]  pkt_cause;
    logic [31:0] alu;
    logic [31:0] eff;
    logic        is_ld;
    logic        is_st;
    logic        illegal;
    logic        misal;
    logic        cap_done;
    logic [5:0]  cap_cause;
    logic [31:0] cap_result;
    logic [31:0] wdata_c;
    logic [3:0]  strb_c;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_c;
    logic [5:0]  fault_cause;
    logic        timeout;
    logic        unused_done;

    assign pkt_cause   = in_pkt[6:1];
    assign alu         = in_pkt[70:39];
    assign eff         = in_pkt[38:7];
    assign unused_done = in_pkt[73];
    assign is_ld       = (in_memaccess == 2'b01);
    assign is_st       = (in_memaccess == 2'b10);

    assign illegal = (is_ld && (in_funct3 == 3'b011 || in_funct3[2:1] == 2'b11))
                   || (is_st && in_funct3 > 3'b010);

    assign misal = (in_funct3[1:0] == 2'b01 && eff[0])
                 || (in_funct3[1:0] == 2'b10 && eff[1:0] != 2'b00);

    // Checks are ordered: an upstream fault outranks anything we detect here.
    always_comb begin
        cap_done   = 1'b1;
        cap_cause  = 6'd0;
        cap_result = alu;
        if (pkt_cause != 6'd0) begin
            cap_cause = pkt_cause;
        end else if (!is_ld && !is_st) begin
            cap_cause = 6'd0;
        end else if (illegal) begin
            cap_cause = 6'd2;
        end else if (misal) begin
            cap_cause  = is_st ? 6'd6 : 6'd4;
            cap_result = eff;
        end else begin
            cap_done = 1'b0;
        end
    end

    always_comb begin
        wdata_c = in_store_data;
        strb_c  = 4'b1111;
        unique case (in_funct3[1:0])
            2'b00: begin
                wdata_c = {4{in_store_data[7:0]}};
                strb_c  = 4'b0001 << eff[1:0];
            end
            2'b01: begin
                wdata_c = {2{in_store_data[15:0]}};
                strb_c  = 4'b0011 << eff[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   lane_b = bus.resp_data[7:0];
            2'b01:   lane_b = bus.resp_data[15:8];
            2'b10:   lane_b = bus.resp_data[23:16];
            default: lane_b = bus.resp_data[31:24];
        endcase
        lane_h = addr_q[1] ? bus.resp_data[31:16] : bus.resp_data[15:0];
        unique case (f3_q)
            3'b000:  load_c = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_c = {24'd0, lane_b};
            3'b001:  load_c = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_c = {16'd0, lane_h};
            default: load_c = bus.resp_data;
        endcase
    end

    assign fault_cause = st_q ? 6'd7 : 6'd5;
    assign timeout     = (RESP_TIMEOUT != 0) && (cnt == LIM);
    assign wb_trap     = |wb_cause;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            cnt           <= '0;
            addr_q        <= '0;
            f3_q          <= '0;
            st_q          <= 1'b0;
            bus.req_valid <= 1'b0;
            bus.req_addr  <= '0;
            bus.req_write <= 1'b0;
            bus.req_wdata <= '0;
            bus.req_wstrb <= '0;
            wb_valid      <= 1'b0;
            wb_result     <= '0;
            wb_cause      <= '0;
            wb_redirect   <= 1'b0;
            wb_cmtype     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready    <= 1'b0;
                        addr_q      <= eff;
                        f3_q        <= in_funct3;
                        st_q        <= is_st;
                        wb_redirect <= in_pkt[0];
                        wb_cmtype   <= in_pkt[72:71];
                        if (cap_done) begin
                            state     <= DONE;
                            wb_valid  <= 1'b1;
                            wb_cause  <= cap_cause;
                            wb_result <= cap_result;
                        end else begin
                            state         <= REQ;
                            bus.req_valid <= 1'b1;
                            bus.req_addr  <= {eff[31:2], 2'b00};
                            bus.req_write <= is_st;
                            bus.req_wdata <= is_st ? wdata_c : 32'd0;
                            bus.req_wstrb <= is_st ? strb_c : 4'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus.req_ready) begin
                        bus.req_valid <= 1'b0;
                        state         <= WAIT;
                        cnt           <= '0;
                    end
                end
                WAIT: begin
                    // A response in the limit cycle still beats the timeout.
                    if (bus.resp_valid) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        if (bus.resp_err) begin
                            wb_cause  <= fault_cause;
                            wb_result <= addr_q;
                        end else begin
                            wb_cause  <= 6'd0;
                            wb_result <= st_q ? 32'd0 : load_c;
                        end
                    end else if (timeout) begin
                        state     <= DONE;
                        wb_valid  <= 1'b1;
                        wb_cause  <= fault_cause;
                        wb_result <= addr_q;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a behavioural
// model of the access rules, plus directed corner cases.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [73:0] in_pkt = '0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_memaccess = '0;
    logic [31:0] in_store_data = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_result;
    logic [5:0]  wb_cause;
    logic        wb_trap;
    logic        wb_redirect;
    logic [1:0]  wb_cmtype;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] obs_res;
    logic [5:0]  obs_cause;
    logic [3:0]  obs_strb;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;
    int          obs_reqcyc;

    mem_access_stage_if bus();

    mem_access_stage #(.RESP_TIMEOUT(T)) dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pkt        (in_pkt),
        .in_funct3     (in_funct3),
        .in_memaccess  (in_memaccess),
        .in_store_data (in_store_data),
        .bus           (bus),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_result     (wb_result),
        .wb_cause      (wb_cause),
        .wb_trap       (wb_trap),
        .wb_redirect   (wb_redirect),
        .wb_cmtype     (wb_cmtype)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(
        input logic [31:0] alu, input logic [31:0] addr,
        input logic [5:0] cin, input logic [1:0] cmt, input logic redir,
        input logic [2:0] f3, input logic [1:0] mem, input logic [31:0] sd,
        input int rd, input int dr, input logic err,
        input logic [31:0] rdata, input int hold);
        logic ld, st, bus_op, chkres, tmo;
        logic [5:0] ec;
        logic [31:0] er, ew, v;
        logic [3:0] es;
        int size, off, n;

        ld = (mem == 2'd1);
        st = (mem == 2'd2);
        off = int'(addr[1:0]);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        bus_op = 1'b0;
        chkres = 1'b1;
        tmo = (dr >= T);
        ec = 6'd0;
        er = alu;
        ew = 32'd0;
        es = 4'd0;
        if (cin != 0) begin
            ec = cin;
        end else if (!ld && !st) begin
            ec = 6'd0;
        end else if ((ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2)) begin
            ec = 6'd2;
            chkres = 1'b0;
        end else if (addr % size != 0) begin
            ec = st ? 6'd6 : 6'd4;
            er = addr;
        end else begin
            bus_op = 1'b1;
            if (size == 1) begin
                es = 4'(1 << off);
                ew = {24'd0, sd[7:0]} * 32'h0101_0101;
            end else if (size == 2) begin
                es = 4'(3 << off);
                ew = {16'd0, sd[15:0]} * 32'h0001_0001;
            end else begin
                es = 4'hF;
                ew = sd;
            end
            if (tmo || err) begin
                ec = st ? 6'd7 : 6'd5;
                chkres = 1'b0;
            end else if (st) begin
                er = 32'd0;
            end else begin
                v = rdata >> (8 * off);
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (f3 < 4 && v[7]) v = v | 32'hFFFF_FF00;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (f3 < 4 && v[15]) v = v | 32'hFFFF_0000;
                end else begin
                    v = rdata;
                end
                er = v;
            end
        end

        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready", {31'd0, in_ready}, 32'd1);

        in_pkt = {1'b0, cmt, alu, addr, cin, redir};
        in_funct3 = f3;
        in_memaccess = mem;
        in_store_data = sd;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("busy", {31'd0, in_ready}, 32'd0);
        obs_reqcyc = 0;

        if (!bus_op) begin
            chk("nobus_req", {31'd0, bus.req_valid}, 32'd0);
            chk("lat_direct", {31'd0, wb_valid}, 32'd1);
        end else begin
            obs_addr = bus.req_addr;
            obs_strb = bus.req_wstrb;
            obs_wdata = bus.req_wdata;
            chk("req_addr", bus.req_addr, addr & 32'hFFFF_FFFC);
            chk("req_write", {31'd0, bus.req_write}, {31'd0, st});
            if (st) begin
                chk("req_wstrb", {28'd0, bus.req_wstrb}, {28'd0, es});
                chk("req_wdata", bus.req_wdata, ew);
            end
            for (int i = 0; i <= rd; i++) begin
                if (bus.req_valid) obs_reqcyc++;
                if (i == rd) bus.req_ready = 1'b1;
                step();
                bus.req_ready = 1'b0;
            end
            chk("req_held", 32'(obs_reqcyc), 32'(rd + 1));
            chk("req_drop", {31'd0, bus.req_valid}, 32'd0);
            n = 0;
            while (1) begin
                if (n == dr && !tmo) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_err = err;
                    bus.resp_data = rdata;
                end
                step();
                bus.resp_valid = 1'b0;
                bus.resp_err = 1'b0;
                n++;
                if (wb_valid || n > 40) break;
            end
            chk("lat_bus", 32'(n), tmo ? 32'(T) : 32'(dr + 1));
        end

        chk("wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_cause", {26'd0, wb_cause}, {26'd0, ec});
        chk("wb_trap", {31'd0, wb_trap}, {31'd0, (ec != 0)});
        chk("wb_redirect", {31'd0, wb_redirect}, {31'd0, redir});
        chk("wb_cmtype", {30'd0, wb_cmtype}, {30'd0, cmt});
        if (chkres) chk("wb_result", wb_result, er);
        obs_res = wb_result;
        obs_cause = wb_cause;

        if (bus_op && tmo) begin
            bus.resp_valid = 1'b1;
            bus.resp_data = 32'h5555_5555;
            step();
            bus.resp_valid = 1'b0;
            chk("late_resp", {26'd0, wb_cause}, {26'd0, ec});
        end
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", {31'd0, wb_valid}, 32'd1);
            chk("hold_result", wb_result, obs_res);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("wb_drop", {31'd0, wb_valid}, 32'd0);
        chk("re_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data = '0;
        bus.resp_err = 1'b0;

        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_cause", {26'd0, wb_cause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        run_op(32'h1234, 32'h0, 6'd0, 2'd1, 1'b1, 3'd0, 2'd0, 32'd0,
               0, 0, 1'b0, 32'd0, 0);
        chk("alu_pass", obs_res, 32'h1234);

        run_op(32'h0, 32'h1003, 6'd0, 2'd0, 1'b0, 3'b000, 2'd1, 32'd0,
               0, 1, 1'b0, 32'h80FF_FFFF, 1);
        chk("lb_addr", obs_addr, 32'h1000);
        chk("lb_res", obs_res, 32'hFFFF_FF80);
        run_op(32'h0, 32'h1003, 6'd0, 2'd0, 1'b0, 3'b100, 2'd1, 32'd0,
               0, 0, 1'b0, 32'h80FF_FFFF, 0);
        chk("lbu_res", obs_res, 32'h0000_0080);

        run_op(32'h0, 32'h2002, 6'd0, 2'd2, 1'b0, 3'b001, 2'd2, 32'hAAAA_BEEF,
               3, 2, 1'b0, 32'd0, 0);
        chk("sh_cycles", 32'(obs_reqcyc), 32'd4);
        chk("sh_strb", {28'd0, obs_strb}, 32'hC);
        chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
        chk("sh_res", obs_res, 32'd0);

        run_op(32'h0, 32'h3001, 6'd0, 2'd0, 1'b0, 3'b010, 2'd1, 32'd0,
               0, 0, 1'b0, 32'd0, 0);
        chk("lw_mis_cause", {26'd0, obs_cause}, 32'd4);
        chk("lw_mis_res", obs_res, 32'h3001);
        run_op(32'h77, 32'h4000, 6'd3, 2'd0, 1'b0, 3'b010, 2'd1, 32'd0,
               0, 0, 1'b0, 32'd0, 0);
        chk("pass_cause", {26'd0, obs_cause}, 32'd3);

        run_op(32'h0, 32'h5000, 6'd0, 2'd0, 1'b0, 3'b010, 2'd1, 32'd0,
               0, 9, 1'b0, 32'd0, 0);
        chk("tmo_cause", {26'd0, obs_cause}, 32'd5);
        run_op(32'h0, 32'h5004, 6'd0, 2'd0, 1'b0, 3'b010, 2'd1, 32'd0,
               1, 3, 1'b0, 32'hCAFE_F00D, 0);
        chk("after_tmo", obs_res, 32'hCAFE_F00D);

        in_pkt = {1'b0, 2'd0, 32'd0, 32'h6000, 6'd0, 1'b0};
        in_funct3 = 3'b010;
        in_memaccess = 2'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_req", {31'd0, bus.req_valid}, 32'd0);
        chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("arst_result", wb_result, 32'd0);
        chk("arst_trap", {31'd0, wb_trap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        bus.resp_valid = 1'b1;
        step();
        bus.resp_valid = 1'b0;
        chk("stale_resp", {31'd0, wb_valid}, 32'd0);
        chk("stale_ready", {31'd0, in_ready}, 32'd1);

        for (int k = 0; k < 250; k++) begin
            run_op($urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 5),
                   ($urandom_range(0, 5) == 0), $urandom, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Execute-to-writeback memory stage; sits directly downstream of the ALU and consumes its 74-bit result packet.
- Non-memory ops pass through to writeback.
- Loads and stores perform one data-bus transaction, with alignment checks, byte-lane steering, load sign/zero extension and a response timeout.
- Single-entry: one instruction in flight.

Parameters:
- RESP_TIMEOUT, 255: maximum WAIT-state cycles before the access is declared a fault. 0 disables the timeout.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU packet valid.
- in_ready  out  1  stage can accept a packet.
- in_pkt  in  74  ALU packet: [73] done, [72:71] cmtype, [70:39] aluresult, [38:7] effective address, [6:1] cause, [0] redirect.
- in_funct3  in  3  access size/sign.
- in_memaccess  in  2  00 none, 01 load, 10 store, 11 treated as none.
- in_store_data  in  32  rs2 value for stores.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts request.
- req_addr  out  32  word-aligned address: effaddr with [1:0] forced to 00.
- req_write  out  1  1 = store.
- req_wdata  out  32  lane-replicated store data.
- req_wstrb  out  4  byte enables.
- resp_valid  in  1  bus response valid.
- resp_data  in  32  read data.
- resp_err  in  1  bus error.
- wb_valid  out  1  writeback packet valid.
- wb_ready  in  1  writeback consumer accepts.
- wb_result  out  32  result value.
- wb_cause  out  6  exception cause, 0 = none.
- wb_trap  out  1  wb_cause != 0.
- wb_redirect  out  1  in_pkt[0], registered.
- wb_cmtype  out  2  in_pkt[72:71], registered.

Behaviour:
- Reset: async, RST_N low. State=IDLE; in_ready=0 while RST_N low, 1 in IDLE after release. All other outputs 0; timeout counter 0.
- Reset mid-transaction aborts. Any resp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE. in_ready = (state==IDLE). The packet and all side inputs are captured on in_valid&&in_ready.
- Capture decision, in priority order:
  - (a) in_pkt cause != 0: pass cause through, result=aluresult, -> DONE.
  - (b) memaccess none/11: result=aluresult, cause 0, -> DONE.
  - (c) load, funct3 in {011,110,111}, or store, funct3 > 010: cause 2 (illegal), -> DONE.
  - (d) misaligned (half with addr[0]=1, word with addr[1:0]!=0): cause 4 for load, 6 for store, result=effaddr, -> DONE. No bus request is issued.
  - (e) otherwise -> REQ.
- Latency: non-bus ops have wb_valid asserted the cycle after capture.
- REQ: req_valid=1 with address, data and strobes stable until req_ready. The handshake cycle moves to WAIT and clears the counter. req_valid drops the next cycle.
- WAIT: the counter increments each cycle without resp_valid.
  - resp_valid && !resp_err -> DONE with the load result, or result=0 for a store.
  - resp_valid && resp_err -> DONE with cause 5 (load) or 7 (store).
  - Counter reaches RESP_TIMEOUT (RESP_TIMEOUT != 0) before a response -> same fault as resp_err. A response arriving later, in DONE or IDLE, is ignored.
  - resp_valid in the same cycle the counter hits the limit: the response wins.
- Store strobes:
  - SB: 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: 0011 << addr[1:0]; wdata = half replicated x2.
  - SW: 1111; wdata = store data.
- Load extraction:
  - Byte = resp_data[8*addr[1:0] +: 8].
  - Half = resp_data[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- DONE: wb_* stable while wb_valid=1 and !wb_ready.
  - wb_valid&&wb_ready -> IDLE; in_ready rises the next cycle. There is no same-cycle re-accept.
- wb_trap = |wb_cause. wb_redirect and wb_cmtype are passed through unchanged for all paths.

Test Plan:
- ALU packet aluresult=0x0000_1234, memaccess=00, wb_ready=1 -> wb_valid one cycle after accept, wb_result=0x1234, wb_cause=0, no req_valid.
- LB at effaddr 0x1003, resp_data=0x80FF_FFFF -> req_addr=0x1000, req_write=0, wb_result=0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SH at 0x2002, store_data=0xAAAA_BEEF, req_ready delayed 3 cycles -> req_valid held for 4 cycles with req_wstrb=1100, req_wdata=0xBEEF_BEEF. After the response, wb_result=0.
- LW at 0x3001 -> no bus request; wb_cause=4, wb_trap=1, wb_result=0x3001. Incoming packet cause=3 on a load -> cause 3 is passed through with no bus request.
- RESP_TIMEOUT=4, load with no response -> wb_cause=5 after 4 WAIT cycles. A late resp_valid is then ignored and the next packet is processed normally.
- Load in WAIT, RST_N pulsed low -> all outputs 0 immediately, in_ready=1 after release. A stale resp_valid is ignored.
